// File: rtl/obuftds_bus_sched_if.sv
// Bus bundle between the requesters and the OBUFTDS lane scheduler.
// master = requester side, slave = scheduler side.
interface obuftds_bus_sched_if #(
    parameter int LANES = 2,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LANES-1:0] data;
    logic [NREQ-1:0]       last;
    logic [NREQ-1:0]       gnt;
    logic [LANES-1:0]      buf_i;
    logic [LANES-1:0]      buf_t;
    logic                  busy;
    logic                  abort;

    modport master (
        output req, data, last,
        input  gnt, buf_i, buf_t, busy, abort
    );

    modport slave (
        input  req, data, last,
        output gnt, buf_i, buf_t, busy, abort
    );
endinterface

// File: rtl/obuftds_bus_sched.sv
// Round-robin owner scheduler for shared differential tristate lanes.
// One driver at a time, fixed tristated gap, bounded tenure.
module obuftds_bus_sched #(
    parameter int LANES    = 2,
    parameter int NREQ     = 2,
    parameter int TURN     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    obuftds_bus_sched_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_TAIL,
        ST_TURN
    } state_t;

    state_t           st_q, st_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [LANES-1:0] bi_q, bi_d;
    logic             bt_q, bt_d;
    logic             ab_q, ab_d;
    logic [PW-1:0]    own_q, own_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tc_q, tc_d;

    logic [PW-1:0]    win;
    logic             any_req;
    logic             own_req;
    logic             own_last;
    logic [LANES-1:0] own_data;
    logic [PW-1:0]    nxt_ptr;
    logic             grab;

    function automatic logic [PW-1:0] rr_idx(logic [PW-1:0] base, int k);
        int j;
        j = int'(base) + k;
        if (j >= NREQ) j = j - NREQ;
        return PW'(j);
    endfunction

    // First requester at or after the pointer, wrapping.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && bus.req[rr_idx(ptr_q, k)]) begin
                any_req = 1'b1;
                win     = rr_idx(ptr_q, k);
            end
        end
    end

    // Select the current owner's request, last flag and beat.
    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (own_q == PW'(r)) begin
                own_req  = bus.req[r];
                own_last = bus.last[r];
                own_data = bus.data[r*LANES +: LANES];
            end
        end
        nxt_ptr = (int'(own_q) == NREQ - 1) ? '0 : own_q + PW'(1);
    end

    // Next state and next registered outputs.
    always_comb begin
        st_d  = st_q;
        gnt_d = gnt_q;
        bi_d  = bi_q;
        bt_d  = bt_q;
        ab_d  = 1'b0;
        own_d = own_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        tc_d  = tc_q;
        grab  = 1'b0;
        unique case (st_q)
            ST_IDLE: grab = any_req;
            ST_DRIVE: begin
                if (own_req) begin
                    bi_d  = own_data;
                    cnt_d = cnt_q + CW'(1);
                    if (own_last || int'(cnt_q) + 1 == MAX_HOLD) begin
                        gnt_d = '0;
                        st_d  = ST_TAIL;
                    end
                end else begin
                    gnt_d = '0;
                    bt_d  = 1'b1;
                    bi_d  = '0;
                    ab_d  = 1'b1;
                    st_d  = ST_TURN;
                    tc_d  = '0;
                    ptr_d = nxt_ptr;
                end
            end
            ST_TAIL: begin
                bt_d  = 1'b1;
                bi_d  = '0;
                st_d  = ST_TURN;
                tc_d  = '0;
                ptr_d = nxt_ptr;
            end
            ST_TURN: begin
                if (int'(tc_q) == TURN - 1) begin
                    grab = any_req;
                    if (!any_req) st_d = ST_IDLE;
                end else begin
                    tc_d = tc_q + TW'(1);
                end
            end
            default: st_d = ST_IDLE;
        endcase
        // Claim cycle: bus driven at idle level before the first beat.
        if (grab) begin
            st_d  = ST_DRIVE;
            gnt_d = NREQ'(1) << win;
            bt_d  = 1'b0;
            bi_d  = '0;
            cnt_d = '0;
            own_d = win;
        end
    end

    // State and output registers, tristated on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            gnt_q <= '0;
            bi_q  <= '0;
            bt_q  <= 1'b1;
            ab_q  <= 1'b0;
            own_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            tc_q  <= '0;
        end else begin
            st_q  <= st_d;
            gnt_q <= gnt_d;
            bi_q  <= bi_d;
            bt_q  <= bt_d;
            ab_q  <= ab_d;
            own_q <= own_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.buf_i = bi_q;
    assign bus.buf_t = {LANES{bt_q}};
    assign bus.busy  = (st_q != ST_IDLE);
    assign bus.abort = ab_q;
endmodule
